// File: rtl/mole_field_driver_pkg.sv
// Shared types, configuration and helpers for the multi-mole LED field driver.
// Optional hit-flash behaviour is selected with the MOLE_HIT_FLASH_EN macro.
package mole_pkg;

  localparam int unsigned N_HOLES     = 8;
  localparam int unsigned POS_W       = 4;
  localparam int unsigned LIFE_W      = 8;
  localparam int unsigned MAX_ACTIVE  = 3;
  localparam int unsigned FLASH_TICKS = 4;

  localparam logic [POS_W-1:0] POS_NONE = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    FLASH = 2'd2
  } hole_state_t;

  // Position 1..N_HOLES to one-hot hole select; anything else selects nothing.
  function automatic logic [N_HOLES-1:0] pos_to_onehot(input logic [POS_W-1:0] pos);
    logic [N_HOLES-1:0] oh;
    oh = '0;
    if ((pos != POS_NONE) && (32'(pos) <= N_HOLES)) begin
      oh = N_HOLES'(1) << (pos - POS_W'(1));
    end
    return oh;
  endfunction

endpackage

// File: rtl/mole_field_driver_if.sv
// Spawner/button/LED bundle between the mole spawner, the board and the field driver.
interface mole_field_driver_if;
  import mole_pkg::*;

  logic               tick;
  logic               spawn_valid;
  logic [POS_W-1:0]   spawn_pos;
  logic [LIFE_W-1:0]  spawn_life;
  logic               spawn_ready;
  logic [N_HOLES-1:0] whack;
  logic [N_HOLES-1:0] leds;
  logic [N_HOLES-1:0] hit_mask;
  logic [N_HOLES-1:0] miss_mask;
  logic               spawn_err;
  logic [POS_W-1:0]   active_cnt;

  modport master (
    output tick, spawn_valid, spawn_pos, spawn_life, whack,
    input  spawn_ready, leds, hit_mask, miss_mask, spawn_err, active_cnt
  );

  modport slave (
    input  tick, spawn_valid, spawn_pos, spawn_life, whack,
    output spawn_ready, leds, hit_mask, miss_mask, spawn_err, active_cnt
  );

endinterface

// File: rtl/mole_field_driver_hole_slot.sv
// One hole: IDLE/UP(/FLASH) FSM with lifetime or flash counter and registered LED/hit/miss.
// FLASH state is reachable only when MOLE_HIT_FLASH_EN is defined.
module mole_hole_slot
  import mole_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_spawn,
  input  logic [LIFE_W-1:0] i_life,
  input  logic              i_whack,
  output hole_state_t       o_state,
  output logic              o_up_nxt_c,
  output logic              o_led,
  output logic              o_hit,
  output logic              o_miss
);

  localparam logic [LIFE_W-1:0] CNT_ONE = LIFE_W'(1);

  hole_state_t       r_state;
  hole_state_t       w_state_nxt;
  logic [LIFE_W-1:0] r_cnt;
  logic [LIFE_W-1:0] w_cnt_nxt;
  logic              r_led;
  logic              r_hit;
  logic              r_miss;
  logic              w_led_nxt;
  logic              w_hit_nxt;
  logic              w_miss_nxt;
  logic              w_last;

  assign w_last = (r_cnt == CNT_ONE);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_led   <= 1'b0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_led   <= w_led_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  // Next state: a whack on an UP hole outranks expiry on the same edge
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_spawn) w_state_nxt = UP;
      end
      UP: begin
        if (i_whack) begin
`ifdef MOLE_HIT_FLASH_EN
          w_state_nxt = FLASH;
`else
          w_state_nxt = IDLE;
`endif
        end else if (i_tick && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      FLASH: begin
        if (i_tick && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter, LED and event pulses
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_led_nxt  = r_led;
    w_hit_nxt  = 1'b0;
    w_miss_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_spawn) begin
          w_cnt_nxt = (i_life == '0) ? CNT_ONE : i_life;
          w_led_nxt = 1'b1;
        end
      end
      UP: begin
        if (i_whack) begin
          w_hit_nxt = 1'b1;
          w_led_nxt = 1'b0;
`ifdef MOLE_HIT_FLASH_EN
          w_cnt_nxt = LIFE_W'(FLASH_TICKS);
`endif
        end else if (i_tick) begin
          if (w_last) begin
            w_miss_nxt = 1'b1;
            w_led_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      FLASH: begin
        // Blink starts dark after the hit and ends dark on the last tick
        if (i_tick) begin
          if (w_last) begin
            w_led_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            w_led_nxt = ~r_led;
          end
        end
      end
      default: begin
        w_led_nxt = 1'b0;
      end
    endcase
  end

  assign o_state    = r_state;
  assign o_up_nxt_c = (w_state_nxt == UP);
  assign o_led      = r_led;
  assign o_hit      = r_hit;
  assign o_miss     = r_miss;

endmodule

// File: rtl/mole_field_driver.sv
// Multi-mole LED field driver: spawn decode/accept, per-hole slots, occupancy accounting.
// Build with MOLE_HIT_FLASH_EN defined to make hit holes blink before going idle.
module mole_field_driver
  import mole_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mole_field_driver_if.slave  bus
);

  logic               r_spawn_ready;
  logic               r_spawn_err;
  logic [POS_W-1:0]   r_active_cnt;

  logic               w_accept;
  logic               w_spawn_ok;
  logic [N_HOLES-1:0] w_target;
  logic [N_HOLES-1:0] w_idle;
  logic [N_HOLES-1:0] w_up_nxt;
  logic [N_HOLES-1:0] w_hole_spawn;
  logic [N_HOLES-1:0] w_led;
  logic [N_HOLES-1:0] w_hit;
  logic [N_HOLES-1:0] w_miss;
  logic [POS_W-1:0]   w_active_nxt;
  hole_state_t        w_state [N_HOLES];

  assign w_accept     = bus.spawn_valid & r_spawn_ready;
  assign w_target     = pos_to_onehot(bus.spawn_pos);
  // A hole leaving UP on this edge is still not IDLE, so it reads as busy
  assign w_spawn_ok   = |(w_target & w_idle);
  assign w_hole_spawn = (w_accept && w_spawn_ok) ? w_target : '0;

  for (genvar g = 0; g < int'(N_HOLES); g++) begin : g_hole
    mole_hole_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (bus.tick),
      .i_spawn    (w_hole_spawn[g]),
      .i_life     (bus.spawn_life),
      .i_whack    (bus.whack[g]),
      .o_state    (w_state[g]),
      .o_up_nxt_c (w_up_nxt[g]),
      .o_led      (w_led[g]),
      .o_hit      (w_hit[g]),
      .o_miss     (w_miss[g])
    );
    assign w_idle[g] = (w_state[g] == IDLE);
  end

  // Occupancy after this edge, so a slot freed now admits a spawn on the next edge
  always_comb begin
    w_active_nxt = '0;
    for (int i = 0; i < int'(N_HOLES); i++) begin
      w_active_nxt = w_active_nxt + POS_W'(w_up_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spawn_ready <= 1'b1;
      r_spawn_err   <= 1'b0;
      r_active_cnt  <= '0;
    end else begin
      r_spawn_ready <= (32'(w_active_nxt) < MAX_ACTIVE);
      r_spawn_err   <= w_accept & ~w_spawn_ok;
      r_active_cnt  <= w_active_nxt;
    end
  end

  assign bus.spawn_ready = r_spawn_ready;
  assign bus.spawn_err   = r_spawn_err;
  assign bus.active_cnt  = r_active_cnt;
  assign bus.leds        = w_led;
  assign bus.hit_mask    = w_hit;
  assign bus.miss_mask   = w_miss;

endmodule
